pic_interrupt_sequencer: RTL and testbench

Clocked control core of the 8259A-compatible PIC. It latches IR requests into IRR, resolves priority against IMR and ISR, and drives INT. It runs the two-pulse 8086-mode INTA handshake, sets and clears ISR, and supplies the interrupt vector and vector-ready strobe to the data bus buffer / read-write logic. Configuration and EOI commands arrive as decoded single-cycle pulses from the read/write logic.

---
 rtl/pic_interrupt_sequencer.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_pic_interrupt_sequencer.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// pic_interrupt_sequencer
//
// Clocked control core of an 8259A-compatible interrupt controller. Latches
// the IR lines into IRR (edge or level triggered), resolves priority against
// IMR and ISR with full nesting, raises INT, runs the 8086-mode two-pulse INTA
// handshake, maintains ISR (manual EOI and automatic EOI) and produces the
// interrupt vector with its drive-enable strobe.
//
// Optional build macro: ROTATION_EN
//   defined   -> rotate-on-EOI (101), rotate-in-AEOI set/clear (100/000) and
//                set-priority (110) commands are honoured.
//   undefined -> those codes are ignored and IR0 is always highest priority.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   ir[7:0]       raw interrupt request lines (synchronous to clk)
//   imr[7:0]      interrupt mask, 1 = masked
//   ltim          1 = level-triggered, 0 = edge-triggered
//   icw2_wr       pulse: vector base <= din[7:3]
//   icw4_wr       pulse: AEOI <= din[1]
//   ocw2_wr       pulse: EOI / rotation command in din
//   din[7:0]      command byte for the write pulses
//   inta_n        interrupt acknowledge, active low (synchronous to clk)
//   int_out       interrupt request to the CPU
//   irr[7:0]      interrupt request register
//   isr[7:0]      in-service register
//   vector[7:0]   interrupt vector byte
//   vector_valid  vector drive enable
// -----------------------------------------------------------------------------
module pic_interrupt_sequencer #(
    parameter int NUM_IR         = 8,
    parameter int SPURIOUS_LEVEL = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_IR-1:0] ir,
    input  logic [NUM_IR-1:0] imr,
    input  logic              ltim,
    input  logic              icw2_wr,
    input  logic              icw4_wr,
    input  logic              ocw2_wr,
    input  logic [7:0]        din,
    input  logic              inta_n,
    output logic              int_out,
    output logic [NUM_IR-1:0] irr,
    output logic [NUM_IR-1:0] isr,
    output logic [7:0]        vector,
    output logic              vector_valid
);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        ACK1,
        ACK2
    } state_t;

    state_t state;
    state_t state_next;

    logic [NUM_IR-1:0] ir_q;
    logic              inta_q;
    logic [4:0]        base;
    logic              aeoi;
    logic [2:0]        level;
    logic              spurious;
    logic [2:0]        lowest;

    logic              inta_fall;
    logic              inta_rise;
    logic [NUM_IR-1:0] pending;
    logic [3:0]        top_any;
    logic [3:0]        top_isr;
    logic              grant;
    logic [2:0]        grant_level;
    logic [NUM_IR-1:0] grant_onehot;

    logic              int_next;
    logic              valid_next;
    logic              take;
    logic              load_vector;
    logic              release_ack;

    logic [NUM_IR-1:0] irr_ack_clr;
    logic [NUM_IR-1:0] isr_set;
    logic [NUM_IR-1:0] isr_clr;
    logic [2:0]        eoi_code;
    logic              unused_din;

    // Returns {found, level} of the highest-priority set bit. The priority
    // ring starts just after 'low' (the current lowest-priority level); the
    // scan runs from lowest to highest so the last hit is the winner.
    function automatic logic [3:0] highest(input logic [7:0] bits, input logic [2:0] low);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            idx = low + 3'(i + 1);
            if (bits[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign inta_fall = !inta_n && inta_q;
    assign inta_rise = inta_n && !inta_q;

    // Fully nested resolution: look at requests and in-service levels together;
    // a grant exists only when the top entry is an unmasked request that is not
    // itself already in service.
    assign pending      = irr & ~imr;
    assign top_any      = highest(pending | isr, lowest);
    assign top_isr      = highest(isr, lowest);
    assign grant_level  = top_any[2:0];
    assign grant        = top_any[3] && pending[grant_level] && !isr[grant_level];
    assign grant_onehot = {{(NUM_IR-1){1'b0}}, 1'b1} << grant_level;

    assign eoi_code   = din[7:5];
    assign unused_din = din[0];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake sequencing. INT stays up in PEND even if the request vanishes;
    // the spurious case is resolved at the first INTA instead.
    always_comb begin
        state_next  = state;
        int_next    = int_out;
        valid_next  = vector_valid;
        take        = 1'b0;
        load_vector = 1'b0;
        release_ack = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_next = PEND;
                    int_next   = 1'b1;
                end
            end
            PEND: begin
                if (inta_fall) begin
                    state_next = ACK1;
                    int_next   = 1'b0;
                    take       = 1'b1;
                end
            end
            ACK1: begin
                if (inta_fall) begin
                    state_next  = ACK2;
                    valid_next  = 1'b1;
                    load_vector = 1'b1;
                end
            end
            ACK2: begin
                if (inta_rise) begin
                    state_next  = IDLE;
                    valid_next  = 1'b0;
                    release_ack = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ISR/IRR update masks. Clears are applied before sets so a set on the
    // same bit in the same cycle wins.
    always_comb begin
        irr_ack_clr = '0;
        isr_set     = '0;
        isr_clr     = '0;
        if (take && grant) begin
            isr_set = grant_onehot;
            if (!ltim) begin
                irr_ack_clr = grant_onehot;
            end
        end
        if (ocw2_wr) begin
            case (eoi_code)
                3'b001: begin
                    if (top_isr[3]) begin
                        isr_clr[top_isr[2:0]] = 1'b1;
                    end
                end
                3'b011: begin
                    isr_clr[din[2:0]] = 1'b1;
                end
`ifdef ROTATION_EN
                3'b101: begin
                    if (top_isr[3]) begin
                        isr_clr[top_isr[2:0]] = 1'b1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
        if (release_ack && aeoi && !spurious) begin
            isr_clr[level] = 1'b1;
        end
    end

    // Datapath registers. A fresh edge on ir[i] re-sets irr[i] even in the
    // cycle its acknowledge clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q         <= '0;
            inta_q       <= 1'b1;
            int_out      <= 1'b0;
            vector_valid <= 1'b0;
            irr          <= '0;
            isr          <= '0;
            vector       <= 8'h00;
            base         <= 5'd0;
            aeoi         <= 1'b0;
            level        <= 3'd0;
            spurious     <= 1'b0;
        end else begin
            ir_q         <= ir;
            inta_q       <= inta_n;
            int_out      <= int_next;
            vector_valid <= valid_next;
            if (ltim) begin
                irr <= ir;
            end else begin
                irr <= (irr & ~irr_ack_clr) | (ir & ~ir_q);
            end
            isr <= (isr & ~isr_clr) | isr_set;
            if (take) begin
                level    <= grant ? grant_level : 3'(SPURIOUS_LEVEL);
                spurious <= !grant;
            end
            if (load_vector) begin
                vector <= {base, level};
            end
            if (icw2_wr) begin
                base <= din[7:3];
            end
            if (icw4_wr) begin
                aeoi <= din[1];
            end
        end
    end

`ifdef ROTATION_EN
    logic rotate_aeoi;

    // Priority rotation: 'lowest' names the lowest-priority level. An explicit
    // command in the same cycle as an automatic rotation takes precedence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lowest      <= 3'd7;
            rotate_aeoi <= 1'b0;
        end else begin
            if (release_ack && aeoi && !spurious && rotate_aeoi) begin
                lowest <= level;
            end
            if (ocw2_wr) begin
                case (eoi_code)
                    3'b101: begin
                        if (top_isr[3]) begin
                            lowest <= top_isr[2:0];
                        end
                    end
                    3'b100: rotate_aeoi <= 1'b1;
                    3'b000: rotate_aeoi <= 1'b0;
                    3'b110: lowest      <= din[2:0];
                    default: begin
                    end
                endcase
            end
        end
    end
`else
    assign lowest = 3'd7;
`endif

endmodule

// File: tb/tb_pic_interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pic_interrupt_sequencer
//
// Self-checking bench for pic_interrupt_sequencer. A behavioural model based on
// priority ranks tracks what every output must be; a compare process checks
// the DUT against it each cycle. Directed scenarios pin the model with literal
// values, then randomized stimulus exercises the remaining behaviour.
// Honours ROTATION_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_pic_interrupt_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] ir = 8'h00;
    logic [7:0] imr = 8'h00;
    logic       ltim = 1'b0;
    logic       icw2_wr = 1'b0;
    logic       icw4_wr = 1'b0;
    logic       ocw2_wr = 1'b0;
    logic [7:0] din = 8'h00;
    logic       inta_n = 1'b1;
    logic       int_out;
    logic [7:0] irr;
    logic [7:0] isr;
    logic [7:0] vector;
    logic       vector_valid;

    int checks = 0;
    int fails  = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    pic_interrupt_sequencer #(
        .NUM_IR(8),
        .SPURIOUS_LEVEL(7)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ir(ir),
        .imr(imr),
        .ltim(ltim),
        .icw2_wr(icw2_wr),
        .icw4_wr(icw4_wr),
        .ocw2_wr(ocw2_wr),
        .din(din),
        .inta_n(inta_n),
        .int_out(int_out),
        .irr(irr),
        .isr(isr),
        .vector(vector),
        .vector_valid(vector_valid)
    );

    // Reference model state. phase: 0 idle, 1 INT raised, 2 first INTA seen,
    // 3 vector on the bus.
    logic [7:0] m_irr = 8'h00;
    logic [7:0] m_isr = 8'h00;
    logic [7:0] m_vec = 8'h00;
    logic [7:0] m_prev_ir = 8'h00;
    logic       m_int = 1'b0;
    logic       m_vv = 1'b0;
    logic       m_prev_inta = 1'b1;
    logic       m_aeoi = 1'b0;
    logic       m_rot_aeoi = 1'b0;
    logic       m_spur = 1'b0;
    logic [4:0] m_base = 5'd0;
    int         m_lowest = 7;
    int         m_level = 0;
    int         m_phase = 0;

    // Rank 0 is highest priority; the level after 'low' is rank 0.
    function automatic int rankOf(input int lvl, input int low);
        return (lvl + 7 - low) % 8;
    endfunction

    function automatic int bestOf(input logic [7:0] bits, input int low);
        int best;
        best = -1;
        for (int l = 0; l < 8; l++) begin
            if (bits[l] && (best < 0 || rankOf(l, low) < rankOf(best, low))) begin
                best = l;
            end
        end
        return best;
    endfunction

    task automatic modelStep();
        int         cand;
        int         top;
        int         n_lowest;
        bit         granted;
        bit         fall;
        bit         rise;
        logic [7:0] n_irr;
        logic [7:0] clr;
        logic [7:0] set;
        fall     = !inta_n && m_prev_inta;
        rise     = inta_n && !m_prev_inta;
        cand     = bestOf(m_irr & ~imr, m_lowest);
        top      = bestOf(m_isr, m_lowest);
        granted  = (cand >= 0) && (top < 0 || rankOf(cand, m_lowest) < rankOf(top, m_lowest));
        n_irr    = ltim ? ir : (m_irr | (ir & ~m_prev_ir));
        clr      = 8'h00;
        set      = 8'h00;
        n_lowest = m_lowest;
        case (m_phase)
            0: begin
                if (granted) begin
                    m_phase = 1;
                    m_int   = 1'b1;
                end
            end
            1: begin
                if (fall) begin
                    m_phase = 2;
                    m_int   = 1'b0;
                    if (granted) begin
                        set[cand] = 1'b1;
                        m_level   = cand;
                        m_spur    = 1'b0;
                        if (!ltim) begin
                            n_irr[cand] = ir[cand] && !m_prev_ir[cand];
                        end
                    end else begin
                        m_level = 7;
                        m_spur  = 1'b1;
                    end
                end
            end
            2: begin
                if (fall) begin
                    m_phase = 3;
                    m_vv    = 1'b1;
                    m_vec   = {m_base, 3'(m_level)};
                end
            end
            default: begin
                if (rise) begin
                    m_phase = 0;
                    m_vv    = 1'b0;
                    if (m_aeoi && !m_spur) begin
                        clr[m_level] = 1'b1;
                        if (m_rot_aeoi) begin
                            n_lowest = m_level;
                        end
                    end
                end
            end
        endcase
        if (ocw2_wr) begin
            case (int'(din[7:5]))
                1: if (top >= 0) clr[top] = 1'b1;
                3: clr[din[2:0]] = 1'b1;
`ifdef ROTATION_EN
                5: begin
                    if (top >= 0) begin
                        clr[top] = 1'b1;
                        n_lowest = top;
                    end
                end
                4: m_rot_aeoi = 1'b1;
                0: m_rot_aeoi = 1'b0;
                6: n_lowest = int'(din[2:0]);
`endif
                default: begin
                end
            endcase
        end
        m_isr       = (m_isr & ~clr) | set;
        m_irr       = n_irr;
        m_lowest    = n_lowest;
        if (icw2_wr) m_base = din[7:3];
        if (icw4_wr) m_aeoi = din[1];
        m_prev_ir   = ir;
        m_prev_inta = inta_n;
    endtask

    // Model advances on the same edges as the DUT, reset asynchronously.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_irr = 8'h00; m_isr = 8'h00; m_vec = 8'h00; m_prev_ir = 8'h00;
            m_int = 1'b0; m_vv = 1'b0; m_prev_inta = 1'b1; m_aeoi = 1'b0;
            m_rot_aeoi = 1'b0; m_spur = 1'b0; m_base = 5'd0;
            m_lowest = 7; m_level = 0; m_phase = 0;
        end else begin
            modelStep();
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%02h expected 0x%02h at %0t", name, actual, expected, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("int_out", {7'b0, int_out}, {7'b0, m_int});
            checkOutput("irr", irr, m_irr);
            checkOutput("isr", isr, m_isr);
            checkOutput("vector", vector, m_vec);
            checkOutput("vector_valid", {7'b0, vector_valid}, {7'b0, m_vv});
        end
    end

    task automatic syncDrive();
        @(posedge clk);
        #1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) syncDrive();
    endtask

    // kind: 0 = ICW2, 1 = ICW4, 2 = OCW2
    task automatic writeCmd(input int kind, input logic [7:0] data);
        din     = data;
        icw2_wr = (kind == 0);
        icw4_wr = (kind == 1);
        ocw2_wr = (kind == 2);
        syncDrive();
        icw2_wr = 1'b0;
        icw4_wr = 1'b0;
        ocw2_wr = 1'b0;
    endtask

    task automatic pulseIr(input logic [7:0] mask);
        ir = ir | mask;
        syncDrive();
        ir = ir & ~mask;
    endtask

    // Two INTA pulses; checks the vector while the second pulse is low.
    task automatic ackCycle(input logic [7:0] exp_vec, input string name);
        inta_n = 1'b0;
        waitCycles(2);
        inta_n = 1'b1;
        waitCycles(2);
        inta_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput({name, "_valid"}, {7'b0, vector_valid}, 8'h01);
        checkOutput(name, vector, exp_vec);
        syncDrive();
        inta_n = 1'b1;
        waitCycles(2);
        @(negedge clk);
        checkOutput({name, "_valid_off"}, {7'b0, vector_valid}, 8'h00);
        syncDrive();
    endtask

    task automatic applyStimulus();
        int sel;
        reset   = ($urandom_range(0, 499) == 0);
        ir      = ir ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
        if ($urandom_range(0, 15) == 0) imr = 8'($urandom) & 8'($urandom);
        if ($urandom_range(0, 63) == 0) ltim = ~ltim;
        if ($urandom_range(0, 2) == 0) inta_n = ~inta_n;
        icw2_wr = 1'b0;
        icw4_wr = 1'b0;
        ocw2_wr = 1'b0;
        sel = $urandom_range(0, 19);
        case (sel)
            0: begin icw2_wr = 1'b1; din = 8'($urandom); end
            1: begin icw4_wr = 1'b1; din = 8'($urandom); end
            2, 3: begin ocw2_wr = 1'b1; din = 8'($urandom); end
            4: begin ocw2_wr = 1'b1; din = 8'h20; end
            default: begin end
        endcase
        syncDrive();
    endtask

    initial begin
        #1 reset = 1'b1;
        #1 cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_int", {7'b0, int_out}, 8'h00);
        checkOutput("reset_irr", irr, 8'h00);
        checkOutput("reset_isr", isr, 8'h00);
        checkOutput("reset_vector", vector, 8'h00);
        checkOutput("reset_valid", {7'b0, vector_valid}, 8'h00);
        syncDrive();
        reset = 1'b0;

        // Basic edge-mode service of IR3 with base 0x08.
        writeCmd(0, 8'h08);
        pulseIr(8'h08);
        syncDrive();
        @(negedge clk);
        checkOutput("t1_irr", irr, 8'h08);
        checkOutput("t1_int", {7'b0, int_out}, 8'h01);
        syncDrive();
        ackCycle(8'h0B, "t1_vector");
        @(negedge clk);
        checkOutput("t1_isr", isr, 8'h08);
        checkOutput("t1_irr_clr", irr, 8'h00);
        syncDrive();

        // Nesting: IR5 blocked by IR3, IR1 preempts.
        pulseIr(8'h20);
        waitCycles(3);
        @(negedge clk);
        checkOutput("t2_blocked_int", {7'b0, int_out}, 8'h00);
        checkOutput("t2_irr", irr, 8'h20);
        syncDrive();
        pulseIr(8'h02);
        syncDrive();
        @(negedge clk);
        checkOutput("t2_int", {7'b0, int_out}, 8'h01);
        syncDrive();
        ackCycle(8'h09, "t2_vector");
        @(negedge clk);
        checkOutput("t2_isr", isr, 8'h0A);
        syncDrive();
        writeCmd(2, 8'h20);
        @(negedge clk);
        checkOutput("t2_eoi_isr", isr, 8'h08);
        syncDrive();
        writeCmd(2, 8'h63);
        syncDrive();
        ackCycle(8'h0D, "t2_ir5_vector");
        writeCmd(2, 8'h20);
        @(negedge clk);
        checkOutput("t2_final_isr", isr, 8'h00);
        syncDrive();

        // Automatic EOI.
        writeCmd(1, 8'h02);
        pulseIr(8'h40);
        syncDrive();
        ackCycle(8'h0E, "t3_vector");
        @(negedge clk);
        checkOutput("t3_aeoi_isr", isr, 8'h00);
        syncDrive();
        writeCmd(1, 8'h00);

        // Level mode, request withdrawn before INTA -> spurious IR7.
        ltim = 1'b1;
        ir   = ir | 8'h04;
        waitCycles(2);
        ir   = ir & ~8'h04;
        syncDrive();
        @(negedge clk);
        checkOutput("t4_irr", irr, 8'h00);
        checkOutput("t4_int_held", {7'b0, int_out}, 8'h01);
        syncDrive();
        ackCycle(8'h0F, "t4_spurious_vector");
        @(negedge clk);
        checkOutput("t4_isr", isr, 8'h00);
        syncDrive();
        ltim = 1'b0;

        // Masking, then specific EOI.
        imr = 8'h10;
        pulseIr(8'h10);
        waitCycles(3);
        @(negedge clk);
        checkOutput("t5_irr", irr, 8'h10);
        checkOutput("t5_masked_int", {7'b0, int_out}, 8'h00);
        syncDrive();
        imr = 8'h00;
        syncDrive();
        @(negedge clk);
        checkOutput("t5_int", {7'b0, int_out}, 8'h01);
        syncDrive();
        ackCycle(8'h0C, "t5_vector");
        writeCmd(2, 8'h64);
        @(negedge clk);
        checkOutput("t5_isr", isr, 8'h00);
        syncDrive();

        // Rotate on non-specific EOI.
        pulseIr(8'h01);
        syncDrive();
        ackCycle(8'h08, "t6_ir0_vector");
        writeCmd(2, 8'hA0);
`ifdef ROTATION_EN
        @(negedge clk);
        checkOutput("t6_rot_isr", isr, 8'h00);
        syncDrive();
        pulseIr(8'h03);
        syncDrive();
        ackCycle(8'h09, "t6_rot_vector");
        @(negedge clk);
        checkOutput("t6_isr", isr, 8'h02);
        checkOutput("t6_irr", irr, 8'h01);
        syncDrive();
        writeCmd(2, 8'h61);
        syncDrive();
        ackCycle(8'h08, "t6_ir0_again");
        writeCmd(2, 8'h20);
        writeCmd(2, 8'hC7);
`else
        @(negedge clk);
        checkOutput("t6_norot_isr", isr, 8'h01);
        syncDrive();
        writeCmd(2, 8'h20);
`endif
        @(negedge clk);
        checkOutput("t6_final_isr", isr, 8'h00);
        syncDrive();

        // Randomized phase against the model.
        for (int n = 0; n < 4000; n++) begin
            applyStimulus();
        end
        reset = 1'b0;
        waitCycles(4);
        @(negedge clk);
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
